alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational 8-bit ALU datapath between two requesters. Each requester issues an operand/opcode bundle over a valid/ready handshake, and a round-robin arbiter grants one request at a time. The block registers the ALU result and zero flag, then returns them to the granted requester over its own response handshake. It sits between the two issuing engines and the single ALU instance, replacing the duplicated ALUs those engines would otherwise need.

## Interface
- DATA_W, 8, operand/result width (ALU fixed at 8; other values unsupported)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept strobe
- req_a, req_b, req_c, req_d  in  2×DATA_W each  per-requester operands
- req_opcode  in  2×4  per-requester opcode
- req_sel  in  2  per-requester SEL_SUM select
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  DATA_W  registered result, shared bus, meaningful only for the bit with rsp_valid set
- rsp_zero  out  1  registered result==0
- rsp_err  out  1  opcode was outside 0–7
- op_count  out  CNT_W  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - grant = requester with valid; if both valid, the one selected by the rr pointer (reset 0).
  - req_ready[grant] = 1 combinationally; all other req_ready bits = 0.
  - On accept, capture operands, opcode, sel and grant id, update rr pointer to the non-granted id, then go to EXEC.
- **EXEC**
  - Captured operands drive the ALU.
  - Result, zero and err are registered.
  - Go to RESP.
- **RESP**
  - rsp_valid[id] = 1. Result, zero and err are held stable until rsp_ready[id].
  - On rsp_ready[id], increment op_count and go to IDLE.
- **Opcode map:** 0 ADD (a+b+c+d), 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SEL_SUM (sel ? a+c : b+d), 7 ADD reverse (d+c+b+a, identical value to 0).
- **Invalid opcodes:** opcode[3]=1 gives result 0, zero 1, err 1.
- **Arithmetic:** all sums and differences are modulo 2^8; carry and borrow are discarded.
- **Boundaries**
  - req_valid is ignored outside IDLE.
  - Requesters may hold req_valid indefinitely; the rr pointer guarantees the other requester is granted within one transaction.
  - A requester deasserting valid without ready has no effect.
  - op_count wraps 0xFFFF→0.
  - rsp_ready on a non-active bit is ignored.
  - rst in any state aborts the in-flight operation; no response is produced.

## Timing
- Reset values:
  - state IDLE
  - req_ready 0 during rst
  - rsp_valid 2'b00
  - rsp_result 0
  - rsp_zero 0
  - rsp_err 0
  - op_count 0
  - rr pointer 0
- **Latency:** accept at edge N gives rsp_valid high from cycle N+2.
- **Throughput:** with rsp_ready tied high, one operation per 3 cycles (accept N, response N+2 accepted, next accept N+3).
- **Outputs:** all outputs are registered except req_ready, which is decoded from state, req_valid and the rr pointer.
- **Backpressure:** with rsp_ready low, RESP holds indefinitely and req_ready stays 0.

## Structure
- Shared package alu_pkg:
  - 3-bit opcode localparams ADD, SUB, AND, OR, XOR, NOT, SEL_SUM, ADD_REV
  - FSM state enum
  - DATA_W default
- Sub-module alu_core: purely combinational ALU (opcode, sel, a–d → result, err), instantiated once.
- This block owns the FSM, arbiter, operand capture and response registers.

## Test plan
- Only req 0: a=10, b=20, c=30, d=40, op 0, rsp_ready=1 → rsp_valid[0] at N+2, result 100, zero 0, op_count 1.
- Both valid after reset, req0 op 1 (a=5, b=5), req1 op 4 (a=0xF0, b=0x0F) → req0 served first with result 0, zero 1; then req1 with 0xFF; grants alternate 0,1,0,1 over 4 back-to-back ops.
- Overflow: op 0 with 0xFF, 0x01, 0x00, 0x00 → 0x00, zero 1; op 1 with a=0, b=1 → 0xFF.
- SEL_SUM: a=1, b=2, c=3, d=4; sel=1 → 4; sel=0 → 6. Invalid opcode 4'b1010 → result 0, zero 1, err 1.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, result and zero stable; req_ready 0 throughout; completes when rsp_ready=1.
- rst asserted during EXEC → next cycle all outputs at reset values, no rsp_valid; a fresh request is accepted immediately after rst drops.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode encodings, FSM state type and default datapath
//            width for the shared ALU arbiter and its combinational core.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_AND     = 3'd2;
    localparam logic [2:0] OP_OR      = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_NOT     = 3'd5;
    localparam logic [2:0] OP_SEL_SUM = 3'd6;
    localparam logic [2:0] OP_ADD_REV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational 8-bit ALU; opcode[3] set flags an error.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        i_opcode,
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_result,
    output logic              o_err
);

    // Sums and differences truncate to DATA_W; carries are dropped.
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        if (i_opcode[3]) begin
            o_err = 1'b1;
        end else begin
            case (i_opcode[2:0])
                OP_ADD:     o_result = i_a + i_b + i_c + i_d;
                OP_SUB:     o_result = i_a - i_b;
                OP_AND:     o_result = i_a & i_b;
                OP_OR:      o_result = i_a | i_b;
                OP_XOR:     o_result = i_a ^ i_b;
                OP_NOT:     o_result = ~i_a;
                OP_SEL_SUM: o_result = i_sel ? (i_a + i_c) : (i_b + i_d);
                OP_ADD_REV: o_result = i_d + i_c + i_b + i_a;
                default:    o_result = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one ALU between two requesters with
//            registered result/zero/err returned over a response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*DATA_W-1:0] req_c,
    input  logic [2*DATA_W-1:0] req_d,
    input  logic [7:0]          req_opcode,
    input  logic [1:0]          req_sel,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [CNT_W-1:0]    op_count
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_rr;
    logic                r_id;
    logic [DATA_W-1:0]   r_a, r_b, r_c, r_d;
    logic [3:0]          r_op;
    logic                r_sel;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_err;
    logic [1:0]          r_rsp_valid;
    logic [CNT_W-1:0]    r_op_count;

    logic                w_grant;
    logic                w_accept;
    logic                w_rsp_done;
    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_err;

    // Contention resolves to the rr pointer; otherwise whoever is valid.
    assign w_grant = (req_valid == 2'b11) ? r_rr : req_valid[1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (|req_valid) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready[r_id]) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 2'b00;
        w_rsp_done = 1'b0;
        if (!rst && (r_state == ST_IDLE) && (|req_valid))
            req_ready[w_grant] = 1'b1;
        if (r_state == ST_RESP)
            w_rsp_done = rsp_ready[r_id];
    end

    assign w_accept = |req_ready;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_opcode (r_op),
        .i_sel    (r_sel),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_c      (r_c),
        .i_d      (r_d),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= 1'b0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_op        <= '0;
            r_sel       <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_id  <= w_grant;
                r_rr  <= ~w_grant;
                r_a   <= req_a[w_grant*DATA_W +: DATA_W];
                r_b   <= req_b[w_grant*DATA_W +: DATA_W];
                r_c   <= req_c[w_grant*DATA_W +: DATA_W];
                r_d   <= req_d[w_grant*DATA_W +: DATA_W];
                r_op  <= req_opcode[w_grant*4 +: 4];
                r_sel <= req_sel[w_grant];
            end
            if (r_state == ST_EXEC) begin
                r_result    <= w_alu_result;
                r_zero      <= (w_alu_result == '0);
                r_err       <= w_alu_err;
                r_rsp_valid <= 2'b01 << r_id;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 2'b00;
                r_op_count  <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a, req_b, req_c, req_d;
    logic [7:0]  req_opcode;
    logic [1:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_d      (req_d),
        .req_opcode (req_opcode),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [3:0] op, input logic sel);
        req_a[id*8 +: 8]      = a;
        req_b[id*8 +: 8]      = b;
        req_c[id*8 +: 8]      = c;
        req_d[id*8 +: 8]      = d;
        req_opcode[id*4 +: 4] = op;
        req_sel[id]           = sel;
    endtask

    // One complete transaction from IDLE with rsp_ready held high.
    task automatic run_op(input string tag, input int id, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                          input logic [3:0] op, input logic sel,
                          input logic [7:0] exp_res, input logic exp_zero, input logic exp_err);
        logic [1:0] onehot;
        onehot = 2'b01 << id;
        load(id, a, b, c, d, op, sel);
        req_valid = onehot;
        rsp_ready = 2'b11;
        #1;
        check({tag, ".req_ready"}, req_ready, onehot);
        tick();
        req_valid = 2'b00;
        check({tag, ".exec_valid"}, rsp_valid, 2'b00);
        tick();
        check({tag, ".rsp_valid"}, rsp_valid, onehot);
        check({tag, ".result"}, rsp_result, exp_res);
        check({tag, ".zero"}, rsp_zero, exp_zero);
        check({tag, ".err"}, rsp_err, exp_err);
        tick();
        exp_cnt++;
        check({tag, ".done_valid"}, rsp_valid, 2'b00);
        check({tag, ".op_count"}, op_count, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b01;
        rsp_ready  = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        req_d      = '0;
        req_opcode = '0;
        req_sel    = '0;
        repeat (3) tick();
        check("rst.req_ready", req_ready, 2'b00);
        check("rst.rsp_valid", rsp_valid, 2'b00);
        check("rst.result", rsp_result, 8'h00);
        check("rst.zero", rsp_zero, 1'b0);
        check("rst.err", rsp_err, 1'b0);
        check("rst.op_count", op_count, 16'h0);
        rst       = 1'b0;
        req_valid = 2'b00;

        run_op("add", 0, 8'd10, 8'd20, 8'd30, 8'd40, 4'd0, 1'b0, 8'd100, 1'b0, 1'b0);

        // Round robin from a fresh reset: grants must alternate 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        load(0, 8'd5, 8'd5, 8'd0, 8'd0, 4'd1, 1'b0);
        load(1, 8'hF0, 8'h0F, 8'd0, 8'd0, 4'd4, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr.req_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            check("rr.rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr.result", rsp_result, (k % 2 == 0) ? 8'h00 : 8'hFF);
            check("rr.zero", rsp_zero, (k % 2 == 0) ? 1'b1 : 1'b0);
            tick();
            exp_cnt++;
            check("rr.op_count", op_count, exp_cnt);
        end
        req_valid = 2'b00;

        run_op("ovf_add", 0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("ovf_sub", 1, 8'h00, 8'h01, 8'h00, 8'h00, 4'd1, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_op("sel1", 0, 8'd1, 8'd2, 8'd3, 8'd4, 4'd6, 1'b1, 8'd4, 1'b0, 1'b0);
        run_op("sel0", 1, 8'd1, 8'd2, 8'd3, 8'd4, 4'd6, 1'b0, 8'd6, 1'b0, 1'b0);
        run_op("inv", 0, 8'd5, 8'd7, 8'd1, 8'd2, 4'b1010, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("and", 1, 8'hCC, 8'hAA, 8'h00, 8'h00, 4'd2, 1'b0, 8'h88, 1'b0, 1'b0);
        run_op("or", 0, 8'hCC, 8'hAA, 8'h00, 8'h00, 4'd3, 1'b0, 8'hEE, 1'b0, 1'b0);
        run_op("not", 1, 8'h0F, 8'h55, 8'h00, 8'h00, 4'd5, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_op("addrev", 0, 8'd10, 8'd20, 8'd30, 8'd40, 4'd7, 1'b0, 8'd100, 1'b0, 1'b0);
        run_op("sub", 1, 8'h10, 8'h30, 8'h00, 8'h00, 4'd1, 1'b0, 8'hE0, 1'b0, 1'b0);

        // Backpressure, with a competing request and a stray ready on bit 0.
        load(1, 8'h12, 8'h21, 8'h00, 8'h00, 4'd3, 1'b0);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("bp.req_ready", req_ready, 2'b10);
        tick();
        load(0, 8'd1, 8'd1, 8'd1, 8'd1, 4'd0, 1'b0);
        req_valid = 2'b01;
        check("bp.exec_valid", rsp_valid, 2'b00);
        tick();
        check("bp.rsp_valid", rsp_valid, 2'b10);
        check("bp.result", rsp_result, 8'h33);
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.hold_valid", rsp_valid, 2'b10);
            check("bp.hold_result", rsp_result, 8'h33);
            check("bp.hold_zero", rsp_zero, 1'b0);
            check("bp.hold_ready", req_ready, 2'b00);
        end
        rsp_ready = 2'b10;
        tick();
        exp_cnt++;
        check("bp.done_valid", rsp_valid, 2'b00);
        check("bp.op_count", op_count, exp_cnt);
        check("bp.next_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();
        tick();
        check("withdraw.rsp_valid", rsp_valid, 2'b00);
        check("withdraw.op_count", op_count, exp_cnt);

        // Reset during EXEC aborts the operation and clears the rr pointer.
        load(0, 8'd1, 8'd2, 8'd3, 8'd4, 4'd0, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        tick();
        rst       = 1'b1;
        req_valid = 2'b11;
        tick();
        check("abort.req_ready", req_ready, 2'b00);
        check("abort.rsp_valid", rsp_valid, 2'b00);
        check("abort.result", rsp_result, 8'h00);
        check("abort.zero", rsp_zero, 1'b0);
        check("abort.err", rsp_err, 1'b0);
        check("abort.op_count", op_count, 16'h0);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("abort.rr_reset", req_ready, 2'b01);
        run_op("fresh", 0, 8'd1, 8'd2, 8'd3, 8'd4, 4'd0, 1'b0, 8'd10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
